// File: rtl/led_panel_pkg.sv
// led_panel_pkg: shared panel geometry, pixel type and stream-writer state encoding
package led_panel_pkg;
    localparam int H_PIXELS  = 64;
    localparam int V_PIXELS  = 64;
    localparam int COL_W     = $clog2(H_PIXELS);
    localparam int ROW_W     = $clog2(V_PIXELS);
    localparam int FB_ADDR_W = COL_W + ROW_W - 1;
    typedef logic [23:0] pixel_t;
    typedef enum logic {IDLE, ACTIVE} state_t;
    function automatic logic [31:0] to_word(input pixel_t p);
        return {8'h00, p};
    endfunction
endpackage

// File: rtl/pixel_xy_counter.sv
// pixel_xy_counter: raster column/row tracker with restart, row advance and frame wrap
module pixel_xy_counter import led_panel_pkg::*; #(
    parameter int H_PIXELS = led_panel_pkg::H_PIXELS,
    parameter int V_PIXELS = led_panel_pkg::V_PIXELS,
    parameter int CW       = $clog2(H_PIXELS),
    parameter int RW       = $clog2(V_PIXELS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          restart,
    input  logic          eol,
    output logic [CW-1:0] cur_col,
    output logic [RW-1:0] cur_row,
    output logic          col_end,
    output logic          row_end,
    output logic          last_pix
);
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    // a restarting beat is placed at (0,0) regardless of the held position
    assign cur_col  = restart ? '0 : col_q;
    assign cur_row  = restart ? '0 : row_q;
    assign col_end  = cur_col == CW'(H_PIXELS - 1);
    assign row_end  = eol || col_end;
    assign last_pix = row_end && cur_row == RW'(V_PIXELS - 1);

    // advance past the written beat; the frame's final pixel wraps back to the origin
    always_ff @(posedge clk) begin
        if (rst || (step && last_pix)) begin
            col_q <= '0;
            row_q <= '0;
        end else if (step) begin
            col_q <= row_end ? '0 : cur_col + 1'b1;
            row_q <= row_end ? cur_row + 1'b1 : cur_row;
        end
    end
endmodule

// File: rtl/pixel_stream_writer.sv
// pixel_stream_writer: turns a SOF/EOL pixel stream into upper/lower half-buffer word writes
module pixel_stream_writer import led_panel_pkg::*; #(
    parameter int H_PIXELS = led_panel_pkg::H_PIXELS,
    parameter int V_PIXELS = led_panel_pkg::V_PIXELS,
    parameter int ADDR_W   = led_panel_pkg::FB_ADDR_W
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              enable,
    input  logic [23:0]       s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tuser,
    input  logic              s_tlast,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [31:0]       fb_wr_data,
    output logic              fb_wr_upper,
    output logic              fb_wr_lower,
    output logic              frame_done,
    output logic              err_sof,
    output logic              err_eol,
    output logic              busy
);
    localparam int CW = $clog2(H_PIXELS);
    localparam int RW = $clog2(V_PIXELS);

    state_t            state_q, state_d;
    logic              accept, wr, restart, sof_err;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              col_end, row_end, last_pix;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic              upper_q, lower_q, done_q, sof_q, eol_q;

    assign s_tready = enable && !axi_rst;
    assign accept   = s_tvalid && s_tready;

    pixel_xy_counter #(
        .H_PIXELS(H_PIXELS),
        .V_PIXELS(V_PIXELS),
        .CW(CW),
        .RW(RW)
    ) u_xy (
        .clk(axi_clk),
        .rst(axi_rst),
        .step(wr),
        .restart(restart),
        .eol(s_tlast),
        .cur_col(cur_col),
        .cur_row(cur_row),
        .col_end(col_end),
        .row_end(row_end),
        .last_pix(last_pix)
    );

    // state register
    always_ff @(posedge axi_clk) begin
        if (axi_rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // decide whether the accepted beat is written and where the frame goes next
    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        restart = 1'b0;
        sof_err = 1'b0;
        case (state_q)
            IDLE: begin
                wr      = accept && s_tuser;
                restart = wr;
            end
            ACTIVE: begin
                wr      = accept;
                restart = accept && s_tuser;
                sof_err = restart;
            end
            default: ;
        endcase
        if (wr)
            state_d = last_pix ? IDLE : ACTIVE;
    end

    // one-cycle write strobes and status pulses, registered alongside the write word
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            upper_q <= 1'b0;
            lower_q <= 1'b0;
            done_q  <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            upper_q <= wr && !cur_row[RW-1];
            lower_q <= wr && cur_row[RW-1];
            done_q  <= wr && last_pix;
            sof_q   <= sof_err;
            eol_q   <= wr && (s_tlast != col_end);
            if (wr) begin
                addr_q <= {cur_row[RW-2:0], cur_col};
                data_q <= to_word(s_tdata);
            end
        end
    end

    // a reset arriving right after an accept cancels that pending write
    assign fb_wr_upper = upper_q && !axi_rst;
    assign fb_wr_lower = lower_q && !axi_rst;
    assign frame_done  = done_q && !axi_rst;
    assign err_sof     = sof_q && !axi_rst;
    assign err_eol     = eol_q && !axi_rst;
    assign fb_addr     = addr_q;
    assign fb_wr_data  = data_q;
    assign busy        = state_q == ACTIVE;
endmodule

// File: tb/tb_pixel_stream_writer.sv
// tb_pixel_stream_writer: randomized stream stimulus checked against a raster reference model
module tb_pixel_stream_writer;
    localparam int H = 64;
    localparam int V = 64;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        enable;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tuser;
    logic        s_tlast;
    logic [10:0] fb_addr;
    logic [31:0] fb_wr_data;
    logic        fb_wr_upper;
    logic        fb_wr_lower;
    logic        frame_done;
    logic        err_sof;
    logic        err_eol;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int eol_cnt = 0;
    int sof_cnt = 0;

    bit          in_frame = 0;
    int          mr = 0;
    int          mc = 0;
    bit          e_wu = 0, e_wl = 0, e_fd = 0, e_es = 0, e_ee = 0;
    logic [10:0] e_addr = '0;
    logic [31:0] e_data = '0;
    bit          acc = 0;

    pixel_stream_writer dut (
        .axi_clk(axi_clk),
        .axi_rst(axi_rst),
        .enable(enable),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .s_tuser(s_tuser),
        .s_tlast(s_tlast),
        .fb_addr(fb_addr),
        .fb_wr_data(fb_wr_data),
        .fb_wr_upper(fb_wr_upper),
        .fb_wr_lower(fb_wr_lower),
        .frame_done(frame_done),
        .err_sof(err_sof),
        .err_eol(err_eol),
        .busy(busy)
    );

    always #5 axi_clk = ~axi_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // compare last cycle's predictions, then predict the registered result of the current inputs
    task automatic tick();
        bit end_row;
        #1;
        check("s_tready", s_tready, enable && !axi_rst);
        check("fb_wr_upper", fb_wr_upper, e_wu && !axi_rst);
        check("fb_wr_lower", fb_wr_lower, e_wl && !axi_rst);
        check("frame_done", frame_done, e_fd && !axi_rst);
        check("err_sof", err_sof, e_es && !axi_rst);
        check("err_eol", err_eol, e_ee && !axi_rst);
        check("busy", busy, in_frame);
        if ((e_wu || e_wl) && !axi_rst) begin
            check("fb_addr", fb_addr, e_addr);
            check("fb_wr_data", fb_wr_data, e_data);
        end
        wr_cnt  += int'(fb_wr_upper) + int'(fb_wr_lower);
        fd_cnt  += int'(frame_done);
        eol_cnt += int'(err_eol);
        sof_cnt += int'(err_sof);
        acc = s_tvalid && enable && !axi_rst;
        {e_wu, e_wl, e_fd, e_es, e_ee} = '0;
        if (axi_rst) begin
            in_frame = 0;
            mr = 0;
            mc = 0;
        end else if (acc && (s_tuser || in_frame)) begin
            if (s_tuser) begin
                e_es = in_frame;
                mr = 0;
                mc = 0;
            end
            e_wu    = mr < V / 2;
            e_wl    = !e_wu;
            e_addr  = 11'((mr % (V / 2)) * H + mc);
            e_data  = {8'h00, s_tdata};
            end_row = s_tlast || mc == H - 1;
            e_ee    = s_tlast != (mc == H - 1);
            e_fd    = end_row && mr == V - 1;
            in_frame = !e_fd;
            if (e_fd) begin
                mr = 0;
                mc = 0;
            end else if (end_row) begin
                mr++;
                mc = 0;
            end else begin
                mc++;
            end
        end
        @(posedge axi_clk);
        @(negedge axi_clk);
    endtask

    task automatic send(input logic [23:0] d, input bit u, input bit l);
        if ($urandom_range(7) == 0) begin
            s_tvalid = 1'b0;
            s_tdata  = 24'($urandom);
            s_tuser  = 1'($urandom);
            s_tlast  = 1'($urandom);
            tick();
        end
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        tick();
        for (int k = 0; k < 50 && !acc; k++)
            tick();
        if (!acc)
            check("accept_timeout", 0, 1);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // one stream frame with optional short row, long row, stray SOF and enable stall
    task automatic send_frame(input logic [23:0] first_d, input int short_r, input int short_c,
                              input int long_r, input int sof_r, input int sof_c, input int stall_r);
        bit u, l;
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                u = (r == 0 && c == 0) || (r == sof_r && c == sof_c);
                l = (r == short_r) ? (c == short_c) : (r == long_r) ? 1'b0 : (c == H - 1);
                if (r == stall_r && c == 10) begin
                    enable   = 1'b0;
                    s_tvalid = 1'b1;
                    s_tdata  = 24'($urandom);
                    s_tuser  = 1'b0;
                    s_tlast  = 1'b0;
                    repeat (7) tick();
                    enable = 1'b1;
                end
                send((r == 0 && c == 0) ? first_d : 24'($urandom), u, l);
                if (r == short_r && c == short_c)
                    break;
            end
        end
    endtask

    initial begin
        axi_rst  = 1'b1;
        enable   = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(negedge axi_clk);
        check("rst_addr", fb_addr, 0);
        check("rst_data", fb_wr_data, 0);
        tick();
        axi_rst = 1'b0;
        enable  = 1'b1;
        tick();

        wr_cnt = 0;
        repeat (3) send(24'hABCDEF, 1'b0, 1'b0);
        tick();
        check("pre_sof_writes", wr_cnt, 0);

        wr_cnt = 0;
        fd_cnt = 0;
        eol_cnt = 0;
        sof_cnt = 0;
        send_frame(24'h123456, -1, -1, -1, -1, -1, -1);
        tick();
        check("clean_writes", wr_cnt, H * V);
        check("clean_done", fd_cnt, 1);
        check("clean_eol_errs", eol_cnt, 0);
        check("clean_sof_errs", sof_cnt, 0);

        eol_cnt = 0;
        fd_cnt = 0;
        send_frame(24'($urandom), 5, 40, 17, -1, -1, 33);
        tick();
        check("defect_eol_errs", eol_cnt, 2);
        check("defect_done", fd_cnt, 1);

        sof_cnt = 0;
        send_frame(24'($urandom), -1, -1, -1, 10, 3, -1);
        tick();
        check("mid_sof_errs", sof_cnt, 1);
        check("mid_sof_busy", busy, 1);

        sof_cnt = 0;
        fd_cnt = 0;
        send_frame(24'($urandom), 50, 7, 60, -1, -1, 40);
        tick();
        check("restart_sof_errs", sof_cnt, 1);
        check("restart_done", fd_cnt, 1);

        send(24'($urandom), 1'b1, 1'b0);
        send(24'($urandom), 1'b0, 1'b0);
        s_tvalid = 1'b1;
        s_tdata  = 24'($urandom);
        axi_rst  = 1'b1;
        tick();
        tick();
        axi_rst = 1'b0;
        s_tvalid = 1'b0;
        tick();
        wr_cnt = 0;
        repeat (4) send(24'($urandom), 1'b0, 1'b0);
        tick();
        check("post_rst_drops", wr_cnt, 0);
        send(24'($urandom), 1'b1, 1'b0);
        repeat (3) send(24'($urandom), 1'b0, 1'b0);
        tick();
        check("post_rst_writes", wr_cnt, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
